multicycle_ctrl_fsm: RTL and testbench

- Main control state machine for the multicycle RISC-V datapath variant.
- Sits directly upstream of the ALU decoder and drives its 2-bit ALU_op input.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Generates all mux selects and write enables for the shared ALU, the unified memory, the IR, the PC and the register file.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 55 +++++
 rtl/multicycle_ctrl_fsm_if.sv | 40 ++++
 rtl/multicycle_ctrl_fsm_imm_src_decoder.sv | 20 ++
 rtl/multicycle_ctrl_fsm.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle RISC-V control path.
// Holds state encoding, opcode constants and control-field encodings.
// Optional trap state guarded by ILLEGAL_OP_TRAP_EN.
package riscv_ctrl_pkg;

    localparam int OPC_W = 7;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        S_HALT     = 4'd11
`endif
    } state_t;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

    // ALU_op codes understood by alu_decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RD1   = 2'b10;

    localparam logic [1:0] SRC_B_RD2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
// illegal_op exists only when ILLEGAL_OP_TRAP_EN is defined.
interface multicycle_ctrl_fsm_if;
    import riscv_ctrl_pkg::*;

    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic [1:0]       ALU_op;
    logic [1:0]       ALU_src_a;
    logic [1:0]       ALU_src_b;
    logic [1:0]       result_src;
    logic             adr_src;
    logic [1:0]       imm_src;
    logic             IR_write;
    logic             PC_write;
    logic             mem_write;
    logic             reg_write;
    logic             instr_done;
`ifdef ILLEGAL_OP_TRAP_EN
    logic             illegal_op;
`endif

    modport master (
        input  opcode, zero,
        output ALU_op, ALU_src_a, ALU_src_b, result_src, adr_src, imm_src,
        output IR_write, PC_write, mem_write, reg_write, instr_done
`ifdef ILLEGAL_OP_TRAP_EN
        , output illegal_op
`endif
    );

    modport slave (
        output opcode, zero,
        input  ALU_op, ALU_src_a, ALU_src_b, result_src, adr_src, imm_src,
        input  IR_write, PC_write, mem_write, reg_write, instr_done
`ifdef ILLEGAL_OP_TRAP_EN
        , input illegal_op
`endif
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_imm_src_decoder.sv
// Combinational opcode-to-immediate-format map; unknown opcodes give I.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic [1:0]       imm_src
);

    // Pick the immediate layout from the opcode alone
    always_comb begin
        imm_src = IMM_I;
        case (opcode)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RISC-V datapath.
// Moore-decoded selects/enables; PC_write also depends on zero in BEQ.
// Optional HALT trap on unknown opcodes under ILLEGAL_OP_TRAP_EN.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.master bus
);

    state_t     state_reg;
    state_t     state_next;

    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic       instr_done;

    // {IR_write, PC_write, mem_write, reg_write, instr_done}
    logic [4:0] enable_raw;
    logic [4:0] enable_gated;
    logic [1:0] imm_src;

    // State register; reset lands in FETCH and aborts any instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and Moore output decode; unlisted outputs stay 0
    always_comb begin
        state_next = S_FETCH;
        alu_op     = ALU_OP_ADD;
        src_a      = SRC_A_PC;
        src_b      = SRC_B_RD2;
        res_src    = RES_ALUOUT;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_write   = 1'b1;
                src_b      = SRC_B_FOUR;
                res_src    = RES_ALURESULT;
                pc_update  = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // ALU computes the branch target OldPC + imm here
                src_a = SRC_A_OLDPC;
                src_b = SRC_B_IMM;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_next = S_HALT;
`else
                        state_next = S_FETCH;
                        instr_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                src_a      = SRC_A_RD1;
                src_b      = SRC_B_IMM;
                state_next = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                res_src    = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECUTER: begin
                src_a      = SRC_A_RD1;
                alu_op     = ALU_OP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                src_a      = SRC_A_RD1;
                src_b      = SRC_B_IMM;
                alu_op     = ALU_OP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                // rd1 - rd2; ALUOut still holds the target from DECODE
                src_a      = SRC_A_RD1;
                alu_op     = ALU_OP_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC <= target from DECODE while ALU forms OldPC + 4 for rd
                src_a      = SRC_A_OLDPC;
                src_b      = SRC_B_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_HALT: begin
                state_next = S_HALT;
            end
`endif
            default: begin
                // Unreachable encoding: everything stays 0, recover to FETCH
                state_next = S_FETCH;
            end
        endcase
    end

    assign enable_raw = {ir_write, pc_update | (branch & bus.zero),
                         mem_write, reg_write, instr_done};

    // Write enables are suppressed for as long as reset is held
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_en_gate
            assign enable_gated[gi] = enable_raw[gi] & ~reset;
        end
    endgenerate

    imm_src_decoder u_imm_src_decoder (
        .opcode  (bus.opcode),
        .imm_src (imm_src)
    );

    assign bus.ALU_op     = alu_op;
    assign bus.ALU_src_a  = src_a;
    assign bus.ALU_src_b  = src_b;
    assign bus.result_src = res_src;
    assign bus.adr_src    = adr_src;
    assign bus.imm_src    = imm_src;
    assign bus.IR_write   = enable_gated[4];
    assign bus.PC_write   = enable_gated[3];
    assign bus.mem_write  = enable_gated[2];
    assign bus.reg_write  = enable_gated[1];
    assign bus.instr_done = enable_gated[0];

`ifdef ILLEGAL_OP_TRAP_EN
    assign bus.illegal_op = (state_reg == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm: vector table, hand-written corner
// sequences and randomized instructions against a per-instruction model.
// Build with ILLEGAL_OP_TRAP_EN to exercise the HALT trap.
module tb_multicycle_ctrl_fsm;
    import riscv_ctrl_pkg::*;

    // Output vector: {ALU_op, src_a, src_b, result_src, adr_src,
    //                 IR_write, PC_write, mem_write, reg_write, instr_done}
    localparam logic [13:0] V_FETCH  = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 5'b11000};
    localparam logic [13:0] V_RST    = {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 5'b00000};
    localparam logic [13:0] V_DEC    = {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 5'b00000};
    localparam logic [13:0] V_DECNOP = {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 5'b00001};
    localparam logic [13:0] V_MEMADR = {2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 5'b00000};
    localparam logic [13:0] V_MEMRD  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 5'b00000};
    localparam logic [13:0] V_MEMWB  = {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 5'b00011};
    localparam logic [13:0] V_MEMWR  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 5'b00101};
    localparam logic [13:0] V_EXECR  = {2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 5'b00000};
    localparam logic [13:0] V_EXECI  = {2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 5'b00000};
    localparam logic [13:0] V_ALUWB  = {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 5'b00011};
    localparam logic [13:0] V_BEQ0   = {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 5'b00001};
    localparam logic [13:0] V_BEQ1   = {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 5'b01001};
    localparam logic [13:0] V_JAL    = {2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 5'b01000};
    localparam logic [13:0] V_HALT   = 14'd0;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        z;
        logic [13:0] exp;
        logic [1:0]  exp_imm;
    } row_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    row_t tbl[64];
    int   n_rows;

    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return 2'b01;
            OP_BRANCH: return 2'b10;
            OP_JAL:    return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic bit is_known(input logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_RTYPE ||
               op == OP_ITYPE || op == OP_BRANCH || op == OP_JAL;
    endfunction

    // Instruction length in cycles, FETCH included
    function automatic int model_len(input logic [6:0] op);
        case (op)
            OP_LOAD:   return 5;
            OP_BRANCH: return 3;
            OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL: return 4;
            default:   return 2;
        endcase
    endfunction

    // Expected outputs in cycle k of instruction op, with zero value z
    function automatic logic [13:0] model_out(input logic [6:0] op, input int k, input logic z);
        logic [13:0] seq[5];
        seq = '{V_FETCH, V_DEC, V_HALT, V_HALT, V_HALT};
        case (op)
            OP_LOAD:   begin seq[2] = V_MEMADR; seq[3] = V_MEMRD; seq[4] = V_MEMWB; end
            OP_STORE:  begin seq[2] = V_MEMADR; seq[3] = V_MEMWR; end
            OP_RTYPE:  begin seq[2] = V_EXECR;  seq[3] = V_ALUWB; end
            OP_ITYPE:  begin seq[2] = V_EXECI;  seq[3] = V_ALUWB; end
            OP_JAL:    begin seq[2] = V_JAL;    seq[3] = V_ALUWB; end
            OP_BRANCH: begin seq[2] = z ? V_BEQ1 : V_BEQ0; end
            default:   begin seq[1] = V_DECNOP; end
        endcase
        return seq[k];
    endfunction

    function automatic logic [13:0] got_vec();
        return {bus.ALU_op, bus.ALU_src_a, bus.ALU_src_b, bus.result_src, bus.adr_src,
                bus.IR_write, bus.PC_write, bus.mem_write, bus.reg_write, bus.instr_done};
    endfunction

    task automatic add_row(input logic r, input logic [6:0] op, input logic z, input logic [13:0] e);
        tbl[n_rows] = '{rst: r, op: op, z: z, exp: e, exp_imm: imm_of(op)};
        n_rows++;
    endtask

    // Drive inputs, wait for the falling edge, compare, advance past next rising edge
    task automatic do_cycle(input string name, input logic r, input logic [6:0] op, input logic z,
                            input logic [13:0] exp, input logic exp_ill);
        logic [13:0] g;
        reset      = r;
        bus.opcode = op;
        bus.zero   = z;
        @(negedge clk);
        g = got_vec();
        n_total++;
        if (g === exp) n_pass++;
        else $display("FAIL %s outputs: got %b expected %b", name, g, exp);
        n_total++;
        if (bus.imm_src === imm_of(op)) n_pass++;
        else $display("FAIL %s imm_src: got %b expected %b", name, bus.imm_src, imm_of(op));
`ifdef ILLEGAL_OP_TRAP_EN
        n_total++;
        if (bus.illegal_op === exp_ill) n_pass++;
        else $display("FAIL %s illegal_op: got %b expected %b", name, bus.illegal_op, exp_ill);
`else
        if (exp_ill) $display("note: %s illegal_op not present in this build", name);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] op;
        logic       z;
        int         sel;
        logic [6:0] ops[6];
        n_pass  = 0;
        n_total = 0;
        n_rows  = 0;
        ops     = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};

        // Vector table: state is FETCH at the first row
        add_row(1'b1, 7'd0, 1'b1, V_RST);
        add_row(1'b0, OP_LOAD, 1'b0, V_FETCH);
        add_row(1'b0, OP_LOAD, 1'b1, V_DEC);
        add_row(1'b0, OP_LOAD, 1'b1, V_MEMADR);
        add_row(1'b0, OP_STORE, 1'b0, V_MEMRD);
        add_row(1'b0, OP_STORE, 1'b1, V_MEMWB);
        add_row(1'b0, OP_STORE, 1'b0, V_FETCH);
        add_row(1'b0, OP_STORE, 1'b0, V_DEC);
        add_row(1'b0, OP_STORE, 1'b1, V_MEMADR);
        add_row(1'b0, OP_STORE, 1'b1, V_MEMWR);
        add_row(1'b0, OP_BRANCH, 1'b0, V_FETCH);
        add_row(1'b0, OP_BRANCH, 1'b0, V_DEC);
        add_row(1'b0, OP_BRANCH, 1'b1, V_BEQ1);
        add_row(1'b0, OP_BRANCH, 1'b1, V_FETCH);
        add_row(1'b0, OP_BRANCH, 1'b1, V_DEC);
        add_row(1'b0, OP_BRANCH, 1'b0, V_BEQ0);
        add_row(1'b0, OP_JAL, 1'b0, V_FETCH);
        add_row(1'b0, OP_JAL, 1'b1, V_DEC);
        add_row(1'b0, OP_JAL, 1'b0, V_JAL);
        add_row(1'b0, OP_JAL, 1'b1, V_ALUWB);
        add_row(1'b0, OP_ITYPE, 1'b0, V_FETCH);
        add_row(1'b0, OP_ITYPE, 1'b0, V_DEC);
        add_row(1'b0, OP_ITYPE, 1'b1, V_EXECI);
        add_row(1'b0, OP_BRANCH, 1'b1, V_ALUWB);
`ifndef ILLEGAL_OP_TRAP_EN
        add_row(1'b0, 7'd0, 1'b0, V_FETCH);
        add_row(1'b0, 7'd0, 1'b0, V_DECNOP);
        add_row(1'b0, 7'b1111111, 1'b1, V_FETCH);
        add_row(1'b0, 7'b1111111, 1'b1, V_DECNOP);
`endif

        reset      = 1'b1;
        bus.opcode = 7'd0;
        bus.zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < n_rows; i++) begin
            $display("row %0d rst=%b op=%b zero=%b", i, tbl[i].rst, tbl[i].op, tbl[i].z);
            do_cycle($sformatf("row%0d", i), tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].exp, 1'b0);
        end

        // Reset held 3 cycles starting in EXECUTER
        do_cycle("rst_fetch", 1'b0, OP_RTYPE, 1'b0, V_FETCH, 1'b0);
        do_cycle("rst_decode", 1'b0, OP_RTYPE, 1'b0, V_DEC, 1'b0);
        do_cycle("rst_in_exec", 1'b1, OP_RTYPE, 1'b1, V_EXECR, 1'b0);
        do_cycle("rst_hold1", 1'b1, OP_RTYPE, 1'b1, V_RST, 1'b0);
        do_cycle("rst_hold2", 1'b1, OP_RTYPE, 1'b1, V_RST, 1'b0);
        do_cycle("rst_release", 1'b0, OP_RTYPE, 1'b0, V_FETCH, 1'b0);
        do_cycle("rst_r_decode", 1'b0, OP_RTYPE, 1'b0, V_DEC, 1'b0);
        do_cycle("rst_r_exec", 1'b0, OP_RTYPE, 1'b1, V_EXECR, 1'b0);
        do_cycle("rst_r_wb", 1'b0, OP_RTYPE, 1'b0, V_ALUWB, 1'b0);
        $display("reset-mid-instruction sequence done");

        // Randomized instructions against the per-instruction model
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 6);
            if (sel < 6) begin
                op = ops[sel];
            end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                op = ops[$urandom_range(0, 5)];
`else
                do op = 7'($urandom); while (is_known(op));
`endif
            end
            $display("rand %0d op=%b cycles=%0d", n, op, model_len(op));
            for (int k = 0; k < model_len(op); k++) begin
                logic [6:0] drv;
                // opcode only matters in DECODE/MEMADR; scramble it elsewhere
                drv = (k == 1 || k == 2) ? op : 7'($urandom);
                z   = 1'($urandom);
                do_cycle($sformatf("rand%0d_k%0d", n, k), 1'b0, drv, z, model_out(op, k, z), 1'b0);
            end
        end

`ifdef ILLEGAL_OP_TRAP_EN
        // Unknown opcode traps in HALT until reset
        do_cycle("trap_fetch", 1'b0, 7'd0, 1'b0, V_FETCH, 1'b0);
        do_cycle("trap_decode", 1'b0, 7'd0, 1'b0, V_DEC, 1'b0);
        for (int k = 0; k < 12; k++) begin
            z = 1'($urandom);
            do_cycle($sformatf("halt%0d", k), 1'b0, 7'($urandom), z, V_HALT, 1'b1);
        end
        do_cycle("halt_rst", 1'b1, OP_LOAD, 1'b0, V_HALT, 1'b1);
        do_cycle("halt_release", 1'b0, OP_LOAD, 1'b0, V_FETCH, 1'b0);
        do_cycle("halt_after_dec", 1'b0, OP_LOAD, 1'b0, V_DEC, 1'b0);
        $display("trap sequence done");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
